// File: rtl/rid_alloc.sv
// Ray-ID allocator: tags incoming rays with a RID from a finite pool and recycles retired RIDs.
// Optional release checker enabled by defining RID_ALLOC_CHECK_EN (in-flight bitmap, sticky err).
module rid_alloc #(
  parameter int RAY_WIDTH = 256,
  parameter int RID_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           arst,
  input  logic [RAY_WIDTH-1:0]           ray_stream_rsc_dat,
  input  logic                           ray_stream_rsc_vld,
  output logic                           ray_stream_rsc_rdy,
  output logic [RAY_WIDTH+RID_WIDTH-1:0] init_req_stream_rsc_dat,
  output logic                           init_req_stream_rsc_vld,
  input  logic                           init_req_stream_rsc_rdy,
  input  logic [RID_WIDTH-1:0]           rid_rel_rsc_dat,
  input  logic                           rid_rel_rsc_vld,
  output logic [RID_WIDTH:0]             inflight_cnt,
  output logic                           err
);

  localparam int N = 1 << RID_WIDTH;
  localparam logic [RID_WIDTH-1:0] RID_MAX = '1;

  typedef enum logic {FRESH = 1'b0, RECYCLE = 1'b1} state_e;

  state_e                         state_q, state_d;
  logic [RID_WIDTH-1:0]           fresh_q;
  logic [RID_WIDTH-1:0]           free_mem [N];
  logic [RID_WIDTH-1:0]           wr_ptr_q, rd_ptr_q;
  logic [RID_WIDTH:0]             free_cnt_q, free_cnt_d;
  logic [RID_WIDTH:0]             inflight_q, inflight_d;
  logic                           out_vld_q;
  logic [RAY_WIDTH+RID_WIDTH-1:0] out_dat_q;

  logic                 rid_avail;
  logic                 accept;
  logic                 pop;
  logic                 rel_ok;
  logic [RID_WIDTH-1:0] alloc_rid;

  // State register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= FRESH;
    else      state_q <= state_d;
  end

  // Next-state: the fresh counter is used exactly once, then the pool runs from the FIFO
  always_comb begin
    state_d = state_q;
    if (state_q == FRESH && accept && fresh_q == RID_MAX) state_d = RECYCLE;
  end

  // State outputs: RID source selection
  always_comb begin
    rid_avail = (state_q == FRESH) || (free_cnt_q != '0);
    alloc_rid = (state_q == FRESH) ? fresh_q : free_mem[rd_ptr_q];
    pop       = accept && (state_q == RECYCLE);
  end

  assign ray_stream_rsc_rdy = rid_avail && (!out_vld_q || init_req_stream_rsc_rdy);
  assign accept             = ray_stream_rsc_vld && ray_stream_rsc_rdy;

`ifdef RID_ALLOC_CHECK_EN
  logic [N-1:0] bitmap_q, bitmap_d;
  logic         err_q;

  // A RID being allocated this cycle still has its bit clear, so a same-cycle release of it is rejected.
  assign rel_ok = rid_rel_rsc_vld && bitmap_q[rid_rel_rsc_dat];

  always_comb begin
    bitmap_d = bitmap_q;
    if (accept) bitmap_d[alloc_rid]       = 1'b1;
    if (rel_ok) bitmap_d[rid_rel_rsc_dat] = 1'b0;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      bitmap_q <= '0;
      err_q    <= 1'b0;
    end else begin
      bitmap_q <= bitmap_d;
      if (rid_rel_rsc_vld && !rel_ok) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign rel_ok = rid_rel_rsc_vld;
  assign err    = 1'b0;
`endif

  always_comb begin
    free_cnt_d = free_cnt_q;
    inflight_d = inflight_q;
    case ({rel_ok, pop})
      2'b10:   free_cnt_d = free_cnt_q + 1'b1;
      2'b01:   free_cnt_d = free_cnt_q - 1'b1;
      default: ;
    endcase
    case ({accept, rel_ok})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: ;
    endcase
  end

  // Free-list storage carries no reset; occupancy is tracked by free_cnt_q
  always_ff @(posedge clk) begin
    if (rel_ok) free_mem[wr_ptr_q] <= rid_rel_rsc_dat;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      fresh_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      free_cnt_q <= '0;
      inflight_q <= '0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
    end else begin
      free_cnt_q <= free_cnt_d;
      inflight_q <= inflight_d;
      if (rel_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      if (accept && state_q == FRESH) fresh_q <= fresh_q + 1'b1;
      if (accept) begin
        out_vld_q <= 1'b1;
        out_dat_q <= {ray_stream_rsc_dat, alloc_rid};
      end else if (init_req_stream_rsc_rdy) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign init_req_stream_rsc_vld = out_vld_q;
  assign init_req_stream_rsc_dat = out_dat_q;
  assign inflight_cnt            = inflight_q;

endmodule

// File: doc/rid_alloc.md
Name: rid_alloc

Overview:
- Front-end stage directly upstream of init.
- Accepts raw 8-word ray records, tags each with a ray ID (RID) drawn from a finite pool, and emits init_req beats of the form {ray, rid}.
- RIDs come back on a release stream when the tail of the pipeline retires a ray. A ray is stalled while no RID is free.
- Bounds the number of in-flight rays to 2**RID_WIDTH.

Parameters:
- RAY_WIDTH, 256, bits of one raw ray record (8 x 32-bit words).
- RID_WIDTH, 8, RID bits. Pool size N = 2**RID_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- arst  in  1  asynchronous reset, active-high.
- ray_stream_rsc_dat  in  RAY_WIDTH  raw ray record.
- ray_stream_rsc_vld  in  1  ray valid.
- ray_stream_rsc_rdy  out  1  ray accepted when vld and rdy.
- init_req_stream_rsc_dat  out  RAY_WIDTH+RID_WIDTH  {ray, rid}; rid occupies the LSBs.
- init_req_stream_rsc_vld  out  1  output valid.
- init_req_stream_rsc_rdy  in  1  downstream (init) ready.
- rid_rel_rsc_dat  in  RID_WIDTH  RID being retired.
- rid_rel_rsc_vld  in  1  release valid; always accepted, no rdy.
- inflight_cnt  out  RID_WIDTH+1  number of RIDs currently allocated.
- err  out  1  sticky release-protocol error (see Optional Feature).

Behaviour:
- Reset (arst=1, asynchronous):
  - init_req_stream_rsc_vld=0, init_req_stream_rsc_dat=0, inflight_cnt=0, err=0.
  - fresh counter=0, free FIFO empty, state=FRESH.
  - Any in-flight data is discarded. Reset mid-stream loses the held output beat; no recovery is required.
- Allocation state machine:
  - FRESH: RIDs are issued from the fresh counter as 0,1,...,N-1 in order. Issuing N-1 moves the state to RECYCLE; the counter does not wrap.
  - RECYCLE: RIDs are issued by popping the free FIFO (depth N, FIFO order). The state never returns to FRESH except through reset.
- RID availability: rid_avail = (state==FRESH) or (free FIFO not empty).
- Output register: single-entry. ray_stream_rsc_rdy = rid_avail and (not out_vld or init_req_stream_rsc_rdy), so a full register with a ready downstream passes one beat per cycle.
- Accept: on vld and rdy, the register loads {ray, rid}, out_vld=1, and the RID source advances (counter increment or FIFO pop). Latency is 1 cycle from accept to init_req_stream_rsc_vld.
- Output hold: out_vld=1 with init_req_stream_rsc_rdy=0 holds dat stable. out_vld clears after a handshake only if no new beat loads in the same cycle.
- Release: rid_rel_rsc_vld pushes rid_rel_rsc_dat into the free FIFO.
  - The FIFO cannot overflow when releases are legal.
  - There is no bypass: a RID released in cycle t is allocatable no earlier than cycle t+1. With the FIFO empty, a simultaneous release and ray stalls the ray for one cycle.
  - A simultaneous push and pop on a non-empty FIFO are both performed in the same cycle.
- inflight_cnt:
  - +1 on accept, -1 on release, unchanged when both occur in the same cycle.
  - Range 0..N; it equals N exactly when rid_avail=0.
- Sustained throughput is 1 ray per cycle while RIDs are available and downstream is ready.

Optional Feature:
- Macro: RID_ALLOC_CHECK_EN.
- Enabled:
  - An N-bit in-flight bitmap is set on allocate and cleared on release.
  - A release of a RID whose bit is 0 (double release, or a RID never issued) is dropped: no FIFO push and no inflight_cnt change. It sets err=1, which stays set until reset.
  - A release of RID r in the same cycle as the allocation of r is treated as illegal.
- Disabled: no bitmap, err is tied 0, and all releases are pushed unconditionally.

Test Plan:
- Fresh order: bench RID_WIDTH=2, downstream rdy=1, 4 rays with data 0xA..0xD. Required: outputs {0xA,0},{0xB,1},{0xC,2},{0xD,3}, each 1 cycle after accept. inflight_cnt=4 and ray_stream_rsc_rdy=0 afterwards.
- Recycle order: from the exhausted state, release RIDs 2 then 0, then send 2 rays. Required: RIDs 2 then 0 are issued. The first ray accepts no earlier than the cycle after release 2, and inflight_cnt returns to 4.
- Backpressure: init_req_stream_rsc_rdy=0 for 5 cycles with out_vld=1. Required: dat stable, ray_stream_rsc_rdy=0, no RID consumed. On rdy=1, one beat per cycle resumes with no loss or duplication.
- Simultaneous events: exhausted pool, release 1 and present a ray in the same cycle. Required: the ray stalls that cycle, accepts the next cycle with RID 1, and inflight_cnt stays 4 → 3 → 4.
- Reset mid-operation: assert arst asynchronously between edges while out_vld=1 and inflight_cnt=3. Required: vld=0, inflight_cnt=0, err=0 immediately; next issued RID is 0.
- Checker (RID_ALLOC_CHECK_EN): release RID 3 twice. Required: second release dropped, err=1 sticky, inflight_cnt decremented only once. With the macro undefined, err stays 0.
